// File: rtl/memory_game_sequencer.sv
// rtl/memory_game_sequencer.sv - round controller for the 4-LED / 4-button memory game
// Generates an LFSR pattern, plays it back, then checks player presses round by round.
module memory_game_sequencer #(
    parameter int          TICKS_ON  = 50_000_000,
    parameter int          TICKS_GAP = 12_500_000,
    parameter int          TIMEOUT   = 250_000_000,
    parameter int          MAX_LEN   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       osc_clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] button,
    output logic [3:0] led,
    output logic [4:0] level,
    output logic       busy,
    output logic       win,
    output logic       fail
);
    localparam int T_A = (TICKS_ON > TICKS_GAP) ? TICKS_ON : TICKS_GAP;
    localparam int T_B = (T_A > TIMEOUT) ? T_A : TIMEOUT;
    localparam int T_C = (T_B > MAX_LEN) ? T_B : MAX_LEN;
    localparam int TW  = (T_C > 1) ? $clog2(T_C) : 1;
    localparam int SW  = $clog2(MAX_LEN);

    localparam logic [TW-1:0] ON_LAST  = TW'(TICKS_ON - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(TICKS_GAP - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] GEN_LAST = TW'(MAX_LEN - 1);
    localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GEN      = 3'd1;
    localparam logic [2:0] S_SHOW_ON  = 3'd2;
    localparam logic [2:0] S_SHOW_GAP = 3'd3;
    localparam logic [2:0] S_WAIT_PR  = 3'd4;
    localparam logic [2:0] S_WAIT_REL = 3'd5;
    localparam logic [2:0] S_WIN      = 3'd6;
    localparam logic [2:0] S_FAIL     = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] step_q, step_d;
    logic [4:0]    level_q, level_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [3:0]    led_q, led_d;
    logic          armed_q, armed_d;
    logic [3:0]    btn_s1_q, btn_s_q;
    logic [1:0]    pat_q [MAX_LEN];

    logic       last_step;
    logic [3:0] target;

    assign last_step = ({{(5-SW){1'b0}}, step_q} == (level_q - 5'd1));
    assign target    = 4'b0001 << pat_q[step_q];

    // Pattern storage is deliberately outside the reset domain.
    always_ff @(posedge osc_clk) begin
        if (state_q == S_GEN) begin
            pat_q[timer_q[SW-1:0]] <= lfsr_q[1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step_d  = step_q;
        level_d = level_q;
        lfsr_d  = lfsr_q;
        armed_d = armed_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_GEN;
            S_GEN: begin
                lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
                if (timer_q == GEN_LAST) begin
                    state_d = S_SHOW_ON;
                    level_d = 5'd1;
                    step_d  = '0;
                end
            end
            S_SHOW_ON: if (timer_q == ON_LAST) state_d = S_SHOW_GAP;
            S_SHOW_GAP: begin
                if (timer_q == GAP_LAST) begin
                    if (last_step) begin
                        step_d  = '0;
                        state_d = S_WAIT_PR;
                    end else begin
                        step_d  = step_q + SW'(1);
                        state_d = S_SHOW_ON;
                    end
                end
            end
            S_WAIT_PR: begin
                // A press only counts once the buttons have been seen all-released here.
                armed_d = armed_q | (btn_s_q == 4'b0000);
                if (armed_q && (btn_s_q != 4'b0000)) begin
                    state_d = (btn_s_q == target) ? S_WAIT_REL : S_FAIL;
                end else if (timer_q == TO_LAST) begin
                    state_d = S_FAIL;
                end
            end
            S_WAIT_REL: begin
                if (btn_s_q == 4'b0000) begin
                    if (!last_step) begin
                        step_d  = step_q + SW'(1);
                        state_d = S_WAIT_PR;
                    end else if (level_q == LEN_MAX) begin
                        state_d = S_WIN;
                    end else begin
                        level_d = level_q + 5'd1;
                        step_d  = '0;
                        state_d = S_SHOW_ON;
                    end
                end
            end
            S_WIN, S_FAIL: begin
                if (start) begin
                    state_d = S_GEN;
                    level_d = 5'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == S_WIN) && (timer_q == ON_LAST)) begin
            timer_d = '0;
        end else if ((state_q == S_GEN) || (state_q == S_SHOW_ON) || (state_q == S_SHOW_GAP) ||
                     (state_q == S_WAIT_PR) || (state_q == S_WIN)) begin
            timer_d = timer_q + TW'(1);
        end

        if ((state_d == S_WAIT_PR) && (state_q != S_WAIT_PR)) begin
            armed_d = (btn_s_q == 4'b0000);
        end

        // LED follows the next state so it is registered without extra lag.
        case (state_d)
            S_SHOW_ON:  led_d = 4'b0001 << pat_q[step_d];
            S_WAIT_REL: led_d = btn_s_q;
            S_WIN: begin
                if (state_q != S_WIN)       led_d = 4'b0101;
                else if (timer_q == ON_LAST) led_d = ~led_q;
                else                         led_d = led_q;
            end
            S_FAIL:     led_d = 4'b1111;
            default:    led_d = 4'b0000;
        endcase
    end

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            step_q   <= '0;
            level_q  <= 5'd0;
            lfsr_q   <= LFSR_SEED;
            led_q    <= 4'b0000;
            armed_q  <= 1'b0;
            btn_s1_q <= 4'b0000;
            btn_s_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            step_q   <= step_d;
            level_q  <= level_d;
            lfsr_q   <= lfsr_d;
            led_q    <= led_d;
            armed_q  <= armed_d;
            btn_s1_q <= button;
            btn_s_q  <= btn_s1_q;
        end
    end

    assign led   = led_q;
    assign level = level_q;
    assign busy  = (state_q != S_IDLE) && (state_q != S_WIN) && (state_q != S_FAIL);
    assign win   = (state_q == S_WIN);
    assign fail  = (state_q == S_FAIL);
endmodule

// File: tb/tb_memory_game_sequencer.sv
// tb/tb_memory_game_sequencer.sv - cycle-exact scoreboard bench for memory_game_sequencer
module tb_memory_game_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_s = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [3:0] led;
    logic [4:0] level;
    logic       busy, win, fail;

    memory_game_sequencer #(
        .TICKS_ON(4), .TICKS_GAP(2), .TIMEOUT(20), .MAX_LEN(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .osc_clk(clk), .reset_n(rst_n), .start(start_s), .button(btn),
        .led(led), .level(level), .busy(busy), .win(win), .fail(fail)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] b;
        logic       st;
        logic [3:0] led;
        logic [4:0] lvl;
        logic       busy;
        logic       win;
        logic       fail;
    } vec_t;

    typedef struct packed {
        logic [3:0] b;
        logic       ok;
    } pv_t;

    vec_t        sb[$];
    pv_t         ptab[6];
    int          total = 0;
    int          bad = 0;
    int          vidx = 0;
    string       phase = "init";
    logic [15:0] m_lfsr;
    logic [1:0]  m_pat[4];

    function automatic logic [15:0] adv(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

    task automatic check(input string nm, input logic [11:0] got, input logic [11:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got led=%b lvl=%0d b/w/f=%b want led=%b lvl=%0d b/w/f=%b",
                     nm, got[11:8], got[7:3], got[2:0], want[11:8], want[7:3], want[2:0]);
        end
    endtask

    task automatic push(input logic [3:0] b, input logic st, input logic [3:0] l,
                        input logic [4:0] lv, input logic bz, input logic w, input logic f);
        vec_t v;
        v.b = b; v.st = st; v.led = l; v.lvl = lv; v.busy = bz; v.win = w; v.fail = f;
        sb.push_back(v);
    endtask

    task automatic drain();
        vec_t v;
        while (sb.size() > 0) begin
            v = sb.pop_front();
            btn = v.b;
            start_s = v.st;
            @(posedge clk); #1;
            check($sformatf("%s#%0d", phase, vidx), {led, level, busy, win, fail},
                  {v.led, v.lvl, v.busy, v.win, v.fail});
            vidx++;
        end
        btn = 4'b0000;
        start_s = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; btn = 4'b0000; start_s = 1'b0;
        @(posedge clk); #1;
        check({phase, "_reset"}, {led, level, busy, win, fail}, 12'h000);
        rst_n = 1'b1;
        m_lfsr = 16'hACE1;
        push(0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic t_start();
        push(0, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) push(0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            m_pat[k] = m_lfsr[1:0];
            m_lfsr = adv(m_lfsr);
        end
    endtask

    task automatic t_show(input int lv, input bit poke, input logic [3:0] b);
        for (int s = 0; s < lv; s++) begin
            for (int c = 0; c < 4; c++)
                push(b, poke && s == 0 && c == 1, oh(m_pat[s]), 5'(lv), 1, 0, 0);
            for (int c = 0; c < 2; c++) push(b, 0, 0, 5'(lv), 1, 0, 0);
        end
    endtask

    task automatic t_press(input logic [3:0] b, input int lv);
        for (int i = 0; i < 2; i++) push(b, 0, 0, 5'(lv), 1, 0, 0);
    endtask

    task automatic t_release(input logic [3:0] b, input int lv);
        for (int i = 0; i < 2; i++) push(0, 0, b, 5'(lv), 1, 0, 0);
    endtask

    task automatic t_fail_hold(input int lv, input int n);
        for (int i = 0; i < n; i++) push(4'b0100, 0, 4'b1111, 5'(lv), 0, 0, 1);
    endtask

    initial begin
        ptab[0] = '{b: 4'b0010, ok: 1'b1};
        ptab[1] = '{b: 4'b0001, ok: 1'b0};
        ptab[2] = '{b: 4'b0011, ok: 1'b0};
        ptab[3] = '{b: 4'b0100, ok: 1'b0};
        ptab[4] = '{b: 4'b1000, ok: 1'b0};
        ptab[5] = '{b: 4'b0110, ok: 1'b0};

        phase = "first";
        do_reset(); t_start(); t_show(1, 1, 4'b0000);
        t_press(4'b0010, 1); t_release(4'b0010, 1); t_show(2, 0, 4'b0000);
        drain();

        for (int i = 0; i < 6; i++) begin
            phase = $sformatf("press%0d", i);
            do_reset(); t_start(); t_show(1, 0, 4'b0000);
            t_press(ptab[i].b, 1);
            if (ptab[i].ok) begin
                t_release(ptab[i].b, 1);
                t_show(2, 0, 4'b0000);
            end else begin
                t_fail_hold(1, 3);
            end
            drain();
        end

        phase = "fullgame";
        do_reset(); t_start();
        for (int lv = 1; lv <= 4; lv++) begin
            t_show(lv, 0, 4'b0000);
            for (int s = 0; s < lv; s++) begin
                t_press(oh(m_pat[s]), lv);
                t_release(oh(m_pat[s]), lv);
            end
        end
        for (int i = 0; i < 12; i++)
            push((i % 3 == 1) ? 4'b1111 : 4'b0000, 0, ((i / 4) % 2 == 0) ? 4'b0101 : 4'b1010,
                 4, 0, 1, 0);
        drain();

        phase = "timeout";
        do_reset(); t_start(); t_show(1, 0, 4'b0000);
        for (int i = 0; i < 20; i++) push(0, 0, 0, 1, 1, 0, 0);
        t_fail_hold(1, 3);
        drain();

        phase = "restart";
        t_start(); t_show(1, 0, 4'b0000);
        t_press(oh(m_pat[0]), 1); t_release(oh(m_pat[0]), 1); t_show(2, 0, 4'b0000);
        drain();

        phase = "held";
        do_reset(); t_start(); t_show(1, 0, 4'b0010);
        for (int i = 0; i < 4; i++) push(4'b0010, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) push(4'b0000, 0, 0, 1, 1, 0, 0);
        t_press(4'b0010, 1); t_release(4'b0010, 1); t_show(2, 0, 4'b0000);
        drain();

        phase = "midreset";
        do_reset(); t_start();
        push(0, 0, oh(m_pat[0]), 1, 1, 0, 0);
        push(0, 0, oh(m_pat[0]), 1, 1, 0, 0);
        drain();
        rst_n = 1'b0; #1;
        check("midreset_async", {led, level, busy, win, fail}, 12'h000);
        @(posedge clk); #1;
        check("midreset_hold", {led, level, busy, win, fail}, 12'h000);
        rst_n = 1'b1;
        m_lfsr = 16'hACE1;
        t_start(); t_show(1, 0, 4'b0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
